// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher
//   Buffers decoded accelerator commands in an in-order FIFO and issues each
//   one to its target unit (of four) over a req/ack handshake. At most one
//   command is outstanding per unit. The head of the FIFO stalls while its
//   unit is busy, and commands are never reordered. Commands with a decoder
//   error are dropped and reported. NOP commands are consumed silently. An
//   issue that is not acknowledged within TIMEOUT_CYCLES is abandoned.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command accept handshake
//   cmd_unit_id..cmd_err  decoded command fields and decoder error status
//   unit_req              one-hot issue request (bit = target unit)
//   unit_op..unit_size    issued command fields, held after the request drops
//   unit_ack              per-unit accept of unit_req
//   unit_done             per-unit single-cycle completion pulse
//   outstanding           per-unit busy bits
//   fifo_count            FIFO occupancy
//   err_drop              pulse: command dropped because cmd_err was nonzero
//   err_timeout           pulse: issue abandoned after timeout
//   timeout_unit          unit of the most recent timeout
module cmd_dispatcher #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [1:0]                      cmd_unit_id,
  input  logic [1:0]                      cmd_op,
  input  logic [1:0]                      cmd_comp,
  input  logic [3:0]                      cmd_addr,
  input  logic [2:0]                      cmd_size,
  input  logic [1:0]                      cmd_err,
  output logic [3:0]                      unit_req,
  output logic [1:0]                      unit_op,
  output logic [1:0]                      unit_comp,
  output logic [3:0]                      unit_addr,
  output logic [2:0]                      unit_size,
  input  logic [3:0]                      unit_ack,
  input  logic [3:0]                      unit_done,
  output logic [3:0]                      outstanding,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            err_drop,
  output logic                            err_timeout,
  output logic [1:0]                      timeout_unit
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  // The counter starts at 0 in the first request cycle, so the last allowed
  // cycle is the one where it reads TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t state, state_nx;

  // FIFO entry layout: {unit[12:11], op[10:9], comp[8:7], addr[6:3], size[2:0]}
  logic [12:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [12:0]   head;
  logic [1:0]    head_unit;
  logic          head_free;

  logic          accept, push, pop, drop;
  logic          ack_hit, timeout_hit, in_issue;
  logic [1:0]    issue_unit;
  logic [TW-1:0] to_cnt;
  logic [3:0]    ack_set;

  assign cmd_ready   = (fifo_count < DEPTH_C);
  assign accept      = cmd_valid & cmd_ready;
  assign drop        = accept & (cmd_err != 2'b00);
  assign push        = accept & (cmd_err == 2'b00) & (cmd_op != 2'b00);

  assign head        = mem[rd_ptr];
  assign head_unit   = head[12:11];
  // A done pulse in the same cycle frees the unit for the head command.
  assign head_free   = ~outstanding[head_unit] | unit_done[head_unit];

  assign in_issue    = (state == S_ISSUE);
  // unit_req is one-hot on the issued unit, so acks on other bits fall out.
  assign ack_hit     = |(unit_ack & unit_req);
  // An ack in the final cycle takes priority over the timeout.
  assign timeout_hit = ~ack_hit & (to_cnt == TO_LAST);
  assign ack_set     = (in_issue && ack_hit) ? unit_req : 4'b0000;

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_count != '0 || push) state_nx = S_CHECK;
      end
      S_CHECK: begin
        if (fifo_count != '0 && head_free) begin
          pop      = 1'b1;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ack_hit || timeout_hit)
          state_nx = (fifo_count != '0 || push) ? S_CHECK : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // FIFO storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_unit_id, cmd_op, cmd_comp, cmd_addr, cmd_size};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_req     <= '0;
      unit_op      <= '0;
      unit_comp    <= '0;
      unit_addr    <= '0;
      unit_size    <= '0;
      issue_unit   <= '0;
      to_cnt       <= '0;
      outstanding  <= '0;
      err_drop     <= 1'b0;
      err_timeout  <= 1'b0;
      timeout_unit <= '0;
    end else begin
      err_drop    <= drop;
      err_timeout <= in_issue & timeout_hit;
      // A done pulse coinciding with an ack to the same unit leaves it busy.
      outstanding <= (outstanding & ~unit_done) | ack_set;

      if (pop) begin
        unit_req   <= 4'b0001 << head_unit;
        unit_op    <= head[10:9];
        unit_comp  <= head[8:7];
        unit_addr  <= head[6:3];
        unit_size  <= head[2:0];
        issue_unit <= head_unit;
        to_cnt     <= '0;
      end else if (in_issue) begin
        if (ack_hit || timeout_hit) unit_req <= '0;
        else                        to_cnt   <= to_cnt + TW'(1);
      end

      if (in_issue && timeout_hit) timeout_unit <= issue_unit;
    end
  end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Testbench for cmd_dispatcher (FIFO_DEPTH=4, TIMEOUT_CYCLES=8).
// Expected issues are queued as commands are accepted and compared when the
// DUT raises a new unit_req; handshake timing and status are checked inline.
module tb_cmd_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_unit_id, cmd_op, cmd_comp, cmd_err;
  logic [3:0] cmd_addr;
  logic [2:0] cmd_size;
  logic [3:0] unit_req, unit_ack, unit_done, outstanding, unit_addr;
  logic [1:0] unit_op, unit_comp, timeout_unit;
  logic [2:0] unit_size, fifo_count;
  logic       err_drop, err_timeout;

  int tests  = 0;
  int failed = 0;
  logic [14:0] sb [$];
  logic [3:0]  prev_req = 4'b0000;

  cmd_dispatcher #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_unit_id(cmd_unit_id), .cmd_op(cmd_op), .cmd_comp(cmd_comp),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_err(cmd_err),
    .unit_req(unit_req), .unit_op(unit_op), .unit_comp(unit_comp),
    .unit_addr(unit_addr), .unit_size(unit_size),
    .unit_ack(unit_ack), .unit_done(unit_done),
    .outstanding(outstanding), .fifo_count(fifo_count),
    .err_drop(err_drop), .err_timeout(err_timeout), .timeout_unit(timeout_unit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one command until accepted (bounded), then release cmd_valid.
  task automatic send(input logic [1:0] u, input logic [1:0] op, input logic [1:0] comp,
                      input logic [3:0] addr, input logic [2:0] size, input logic [1:0] err);
    int n = 0;
    cmd_valid = 1'b1; cmd_unit_id = u; cmd_op = op; cmd_comp = comp;
    cmd_addr = addr; cmd_size = size; cmd_err = err;
    while (!cmd_ready && n < 50) begin step(); n++; end
    if (n >= 50) chk("send_wait_ready", 0, 1);
    step();
    if (err == 2'b00 && op != 2'b00) sb.push_back({4'b0001 << u, op, comp, addr, size});
    cmd_valid = 1'b0;
  endtask

  // Scoreboard: every new request must match the oldest accepted command.
  always @(negedge clk) begin
    if (rst_n && unit_req != 4'b0000 && prev_req == 4'b0000) begin
      if (sb.size() == 0) chk("issue_unexpected", {28'b0, unit_req}, 0);
      else chk("issue_fields", {unit_req, unit_op, unit_comp, unit_addr, unit_size}, sb.pop_front());
    end
    prev_req = unit_req;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_unit_id = 0; cmd_op = 0; cmd_comp = 0;
    cmd_addr = 0; cmd_size = 0; cmd_err = 0; unit_ack = 0; unit_done = 0;
    step(); step();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_outputs", {unit_req, unit_op, unit_comp, unit_addr, unit_size, outstanding,
                        fifo_count, err_drop, err_timeout, timeout_unit}, 0);
    rst_n = 1'b1;
    step();

    // Single LOAD to unit 2, acked in the first request cycle.
    unit_ack = 4'b0100;
    send(2'd2, 2'b01, 2'b00, 4'd5, 3'd3, 2'b00);
    chk("t1_count_n1", fifo_count, 1);
    chk("t1_req_n1", unit_req, 0);
    step();
    chk("t1_req_n2", unit_req, 4'b0100);
    chk("t1_fields", {unit_op, unit_addr, unit_size}, {2'b01, 4'd5, 3'd3});
    step();
    chk("t1_req_drop", unit_req, 0);
    chk("t1_out_set", outstanding, 4'b0100);
    chk("t1_fields_held", {unit_op, unit_addr, unit_size}, {2'b01, 4'd5, 3'd3});
    step(); step();
    unit_done = 4'b0100;
    #1 chk("t1_out_during_done", outstanding, 4'b0100);
    step();
    unit_done = 4'b0000;
    chk("t1_out_clear", outstanding, 0);

    // Two COMPUTEs to unit 1 then one to unit 3: strict in-order stall.
    unit_ack = 4'b1010;
    send(2'd1, 2'b11, 2'b01, 4'd7, 3'd2, 2'b00);
    send(2'd1, 2'b11, 2'b10, 4'd9, 3'd4, 2'b00);
    send(2'd3, 2'b11, 2'b11, 4'd1, 3'd6, 2'b00);
    chk("t2_out_busy", outstanding, 4'b0010);
    for (int i = 0; i < 9; i++) begin
      chk("t2_stall_req", unit_req, 0);
      chk("t2_stall_count", fifo_count, 2);
      step();
    end
    unit_done = 4'b0010;
    step();
    unit_done = 4'b0000;
    chk("t2_second_issue", unit_req, 4'b0010);
    step();
    chk("t2_gap", unit_req, 0);
    step();
    chk("t2_third_issue", unit_req, 4'b1000);
    step();
    chk("t2_out_both", outstanding, 4'b1010);
    unit_done = 4'b1010;
    step();
    unit_done = 4'b0000;
    chk("t2_out_clear", outstanding, 0);

    // Fill the FIFO behind a busy unit 0.
    unit_ack = 4'b0001;
    send(2'd0, 2'b01, 2'b00, 4'd0, 3'd1, 2'b00);
    step(); step();
    chk("t3_out0", outstanding, 4'b0001);
    for (int i = 1; i <= 4; i++) send(2'd0, 2'b10, 2'b00, 4'(i), 3'(i), 2'b00);
    chk("t3_full_count", fifo_count, 4);
    chk("t3_full_ready", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_unit_id = 2'd0; cmd_op = 2'b01; cmd_comp = 2'b00;
    cmd_addr = 4'd15; cmd_size = 3'd7; cmd_err = 2'b00;
    step();
    chk("t3_blocked_count", fifo_count, 4);
    step();
    chk("t3_blocked_ready", cmd_ready, 0);
    unit_done = 4'b0001;
    step();
    unit_done = 4'b0000;
    chk("t3_ready_back", cmd_ready, 1);
    chk("t3_count_after_pop", fifo_count, 3);
    chk("t3_issue", unit_req, 4'b0001);
    step();
    sb.push_back({4'b0001, 2'b01, 2'b00, 4'd15, 3'd7});
    cmd_valid = 1'b0;
    chk("t3_fifth_accepted", fifo_count, 4);
    for (int i = 0; i < 40; i++) begin
      unit_done = outstanding;
      step();
    end
    unit_done = 4'b0000;
    step();
    chk("t3_drained", {fifo_count, outstanding}, 0);

    // Decoder error drop and silent NOP.
    unit_ack = 4'b0000;
    send(2'd0, 2'b01, 2'b00, 4'd3, 3'd3, 2'b10);
    chk("t4_err_drop", err_drop, 1);
    chk("t4_err_count", fifo_count, 0);
    send(2'd1, 2'b00, 2'b00, 4'd3, 3'd3, 2'b00);
    chk("t4_nop_no_drop", err_drop, 0);
    chk("t4_nop_count", fifo_count, 0);
    step();
    chk("t4_no_req", unit_req, 0);

    // Timeout on unit 3, next command (unit 2) dispatched afterwards.
    send(2'd3, 2'b01, 2'b01, 4'd11, 3'd5, 2'b00);
    send(2'd2, 2'b10, 2'b00, 4'd12, 3'd2, 2'b00);
    for (int i = 0; i < 8; i++) begin
      chk("t5_req_held", unit_req, 4'b1000);
      chk("t5_no_timeout_yet", err_timeout, 0);
      step();
    end
    chk("t5_req_drop", unit_req, 0);
    chk("t5_err_timeout", err_timeout, 1);
    chk("t5_timeout_unit", timeout_unit, 3);
    chk("t5_out_unchanged", outstanding, 0);
    unit_ack = 4'b0100;
    step();
    chk("t5_next_issue", unit_req, 4'b0100);
    chk("t5_pulse_end", err_timeout, 0);
    step();
    chk("t5_next_out", outstanding, 4'b0100);
    unit_done = 4'b0100;
    step();
    unit_done = 4'b0000;

    // Ack in the final allowed cycle wins over the timeout.
    unit_ack = 4'b0000;
    send(2'd3, 2'b11, 2'b11, 4'd2, 3'd1, 2'b00);
    step();
    for (int i = 0; i < 7; i++) begin
      chk("t5b_req_held", unit_req, 4'b1000);
      step();
    end
    unit_ack = 4'b1000;
    step();
    unit_ack = 4'b0000;
    chk("t5b_no_timeout", {unit_req, err_timeout}, 0);
    chk("t5b_out_set", outstanding, 4'b1000);
    step();
    chk("t5b_no_late_timeout", err_timeout, 0);
    unit_done = 4'b1000;
    step();
    unit_done = 4'b0000;
    chk("sb_empty_before_reset", sb.size(), 0);

    // Reset mid-handshake with three commands queued.
    send(2'd0, 2'b01, 2'b00, 4'd4, 3'd4, 2'b00);
    for (int i = 0; i < 3; i++) send(2'd1, 2'b10, 2'b00, 4'(i), 3'd0, 2'b00);
    chk("t6_pre_req", unit_req, 4'b0001);
    chk("t6_pre_count", fifo_count, 3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_zero", {unit_req, fifo_count, outstanding, err_drop, err_timeout}, 0);
    chk("t6_rst_ready", cmd_ready, 1);
    sb.delete();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      chk("t6_quiet", {unit_req, err_drop, err_timeout, fifo_count}, 0);
    end
    chk("sb_empty_end", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/cmd_dispatcher.md
Name: cmd_dispatcher

Overview:
Sequences decoded accelerator commands onto the four compute/load-store units. Decoded commands are buffered in a small in-order FIFO, and each one is issued to its target unit over a req/ack handshake. The dispatcher tracks one outstanding command per unit and stalls head-of-line while the target unit is busy. It sits between the command decoder and the unit array, and drops erroneous or NOP commands.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)
TIMEOUT_CYCLES, 255, max cycles unit_req may wait for unit_ack before the command is abandoned

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  decoded command present
cmd_ready  out  1  dispatcher can accept a command
cmd_unit_id  in  2  target unit
cmd_op  in  2  00 NOP, 01 LOAD, 10 STORE, 11 COMPUTE
cmd_comp  in  2  00 ADD, 01 MUL, 10 TANH, 11 RELU
cmd_addr  in  4  operand address
cmd_size  in  3  transfer/compute size
cmd_err  in  2  decoder error status; nonzero = invalid
unit_req  out  4  one-hot issue request, bit = unit_id
unit_op  out  2  issued op_code
unit_comp  out  2  issued comp_type
unit_addr  out  4  issued address
unit_size  out  3  issued size
unit_ack  in  4  per-unit accept of unit_req
unit_done  in  4  per-unit single-cycle completion pulse
outstanding  out  4  per-unit busy bits
fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
err_drop  out  1  one-cycle pulse: command dropped for cmd_err≠0
err_timeout  out  1  one-cycle pulse: issue abandoned after timeout
timeout_unit  out  2  unit of last timeout, held until the next one

Behaviour:
- Reset (async, rst_n=0): all outputs 0 except cmd_ready=1. FIFO empty, state IDLE, timeout counter 0. Reset mid-handshake abandons everything without any error pulse.
- Accept: handshake occurs when cmd_valid & cmd_ready. cmd_ready = (fifo_count < FIFO_DEPTH), combinational from registered count.
- On accept with cmd_err≠0: not enqueued; err_drop=1 next cycle.
- On accept with cmd_err=0 and cmd_op=NOP: consumed silently, not enqueued.
- Otherwise the command is enqueued. Simultaneous push and pop in the same cycle leaves count unchanged.
- Push and pop are both allowed when full, provided cmd_ready was 1 that cycle (it is not when full).
- FSM states:
  - IDLE: FIFO empty. Go to CHECK when count>0.
  - CHECK: let free = ~outstanding[head.unit] | unit_done[head.unit]. If free, go to ISSUE: pop the head and register unit_* fields plus one-hot unit_req next cycle. Else stay in CHECK (head-of-line stall; no reordering).
  - ISSUE: hold unit_req and all fields stable until unit_ack[id]=1. On ack, the next cycle sets unit_req=0 and outstanding[id]=1, then go to CHECK if count>0, else IDLE.
  - ISSUE timeout: the counter increments each ISSUE cycle without ack. When it reaches TIMEOUT_CYCLES, drop the command: err_timeout pulse, timeout_unit=id, unit_req=0, outstanding unchanged, return to CHECK/IDLE.
  - Ack arriving in the timeout cycle wins (normal completion, no error).
- Latency: a command enqueued in cycle N to a free unit with an empty FIFO asserts unit_req at N+2. Back-to-back issues to different units with immediate ack are spaced 2 cycles apart.
- unit_done[k] clears outstanding[k] next cycle. If it coincides with an ack to the same unit, outstanding stays 1.
- unit_done to a non-outstanding unit is ignored.
- unit_ack on bits other than the requested one is ignored.
- unit_* fields hold their last issued value when unit_req=0.

Test Plan:
- Single LOAD to unit 2 (op=01, addr=5, size=3), ack in the same cycle as req → unit_req=4'b0100 at N+2 for 1 cycle with fields 01/5/3; outstanding=4'b0100 until unit_done[2], cleared the cycle after.
- Two COMPUTE commands to unit 1 back-to-back, done after 10 cycles → second unit_req stalls until the done cycle, asserts the next cycle; a third command to unit 3 queued behind it also waits (in order).
- Push 5 commands to busy unit 0 with FIFO_DEPTH=4 → cmd_ready=0 after 4 accepts, fifo_count=4; after done on unit 0, cmd_ready returns to 1.
- cmd_err=2'b10 command, then NOP with cmd_err=0 → first: err_drop pulse, count stays 0; second: no pulse, count 0; unit_req never asserts.
- Issue to unit 3, never ack, TIMEOUT_CYCLES=8 → unit_req high for 8 cycles, then err_timeout pulse, timeout_unit=3, outstanding[3]=0, next command dispatched. Repeat with ack in cycle 8 → no err_timeout.
- Assert rst_n=0 while unit_req high and FIFO holds 3 entries → outputs zero immediately, cmd_ready=1, fifo_count=0, no error pulses after release.
